// File: rtl/spi_burst_ram_slave.sv
`default_nettype none
// ============================================================================
// spi_burst_ram_slave : SPI slave owning a single-port RAM, burst read/write
// Revision 1.0
// ============================================================================
module spi_burst_ram_slave #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8,
  parameter int MEM_WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic SS_n,
  input  logic MOSI,
  output logic MISO,
  output logic busy,
  output logic frame_err
);

  localparam int CNT_MAX = (ADDR_SIZE > MEM_WIDTH) ? ADDR_SIZE : MEM_WIDTH;
  localparam int CNT_W   = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0]     ADDR_LAST = CNT_W'(ADDR_SIZE - 1);
  localparam logic [CNT_W-1:0]     WORD_LAST = CNT_W'(MEM_WIDTH - 1);
  localparam logic [ADDR_SIZE-1:0] ADDR_TOP  = ADDR_SIZE'(MEM_DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CHK_CMD   = 3'd1,
    S_ADDR      = 3'd2,
    S_WRITE     = 3'd3,
    S_TURN      = 3'd4,
    S_READ_DATA = 3'd5,
    S_INVALID   = 3'd6
  } state_t;

  state_t                 state_q, state_d;
  logic [ADDR_SIZE-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   op_hi_q, op_hi_d;
  logic                   rd_q, rd_d;
  logic [MEM_WIDTH-1:0]   rx_q, rx_d;
  logic [MEM_WIDTH-1:0]   tx_q, tx_d;
  logic                   miso_q, miso_d;
  logic                   busy_q, busy_d;
  logic                   ferr_q, ferr_d;

  logic [MEM_WIDTH-1:0]   mem_q [MEM_DEPTH];
  logic                   mem_we;
  logic [MEM_WIDTH-1:0]   mem_wdata;
  logic [MEM_WIDTH-1:0]   rd_word;
  logic [ADDR_SIZE-1:0]   addr_inc;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    op_hi_d   = op_hi_q;
    rd_d      = rd_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    miso_d    = miso_q;
    ferr_d    = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = {rx_q[MEM_WIDTH-2:0], MOSI};
    rd_word   = mem_q[addr_q];
    addr_inc  = (addr_q == ADDR_TOP) ? '0 : addr_q + ADDR_SIZE'(1);

    // Deselect wins over everything; only a half-received header or word is an error.
    if ((state_q != S_IDLE) && SS_n) begin
      state_d = S_IDLE;
      miso_d  = 1'b0;
      cnt_d   = '0;
      ferr_d  = (state_q == S_CHK_CMD) || (state_q == S_ADDR) ||
                ((state_q == S_WRITE) && (cnt_q != '0));
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (!SS_n) begin
            state_d = S_CHK_CMD;
            cnt_d   = '0;
          end
        end
        S_CHK_CMD: begin
          if (cnt_q == '0) begin
            op_hi_d = MOSI;
            cnt_d   = CNT_W'(1);
          end else begin
            cnt_d = '0;
            rd_d  = MOSI;
            if (op_hi_q) begin
              state_d = S_INVALID;
              ferr_d  = 1'b1;
            end else begin
              state_d = S_ADDR;
            end
          end
        end
        S_ADDR: begin
          addr_d = {addr_q[ADDR_SIZE-2:0], MOSI};
          if (cnt_q == ADDR_LAST) begin
            cnt_d   = '0;
            state_d = rd_q ? S_TURN : S_WRITE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_WRITE: begin
          rx_d = mem_wdata;
          if (cnt_q == WORD_LAST) begin
            mem_we = 1'b1;
            addr_d = addr_inc;
            cnt_d  = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_TURN: begin
          tx_d    = rd_word;
          miso_d  = rd_word[MEM_WIDTH-1];
          addr_d  = addr_inc;
          cnt_d   = '0;
          state_d = S_READ_DATA;
        end
        S_READ_DATA: begin
          if (cnt_q == WORD_LAST) begin
            tx_d   = rd_word;
            miso_d = rd_word[MEM_WIDTH-1];
            addr_d = addr_inc;
            cnt_d  = '0;
          end else begin
            tx_d   = {tx_q[MEM_WIDTH-2:0], 1'b0};
            miso_d = tx_q[MEM_WIDTH-2];
            cnt_d  = cnt_q + CNT_W'(1);
          end
        end
        S_INVALID: begin
          miso_d = 1'b0;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      op_hi_q <= 1'b0;
      rd_q    <= 1'b0;
      rx_q    <= '0;
      tx_q    <= '0;
      miso_q  <= 1'b0;
      busy_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      op_hi_q <= op_hi_d;
      rd_q    <= rd_d;
      rx_q    <= rx_d;
      tx_q    <= tx_d;
      miso_q  <= miso_d;
      busy_q  <= busy_d;
      ferr_q  <= ferr_d;
    end
  end

  // Array has no reset so its contents survive rst_n.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[addr_q] <= mem_wdata;
    end
  end

  assign MISO      = miso_q;
  assign busy      = busy_q;
  assign frame_err = ferr_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_burst_ram_slave.sv
`default_nettype none
// ============================================================================
// tb_spi_burst_ram_slave : directed bench, default DUT plus 16x12 variant
// Revision 1.0
// ============================================================================
module tb_spi_burst_ram_slave;

  logic clk;
  logic rst_n;
  logic ss_a, mosi_a, miso_a, busy_a, ferr_a;
  logic ss_b, mosi_b, miso_b, busy_b, ferr_b;

  int n_checks = 0;
  int n_pass   = 0;

  spi_burst_ram_slave #(.MEM_DEPTH(256), .ADDR_SIZE(8), .MEM_WIDTH(8)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .SS_n(ss_a), .MOSI(mosi_a),
    .MISO(miso_a), .busy(busy_a), .frame_err(ferr_a)
  );

  spi_burst_ram_slave #(.MEM_DEPTH(16), .ADDR_SIZE(4), .MEM_WIDTH(12)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .SS_n(ss_b), .MOSI(mosi_b),
    .MISO(miso_b), .busy(busy_b), .frame_err(ferr_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic miso_of(input bit sel);
    return sel ? miso_b : miso_a;
  endfunction

  function automatic logic ferr_of(input bit sel);
    return sel ? ferr_b : ferr_a;
  endfunction

  // Drive on the falling edge, return 1 time unit after the sampling edge.
  task automatic step(input bit sel, input logic ss, input logic mosi);
    @(negedge clk);
    if (sel) begin
      ss_b = ss; mosi_b = mosi;
    end else begin
      ss_a = ss; mosi_a = mosi;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input bit sel, input logic [31:0] val, input int n);
    for (int i = n - 1; i >= 0; i--) step(sel, 1'b0, val[i]);
  endtask

  task automatic wr_frame(input bit sel, input int aw, input int w, input logic [31:0] addr,
                          input int n, input logic [31:0] d0, d1, d2, output logic ferr_end);
    logic [31:0] d;
    step(sel, 1'b0, 1'b0);
    send_bits(sel, 32'd0, 2);
    send_bits(sel, addr, aw);
    for (int k = 0; k < n; k++) begin
      d = (k == 0) ? d0 : (k == 1) ? d1 : d2;
      send_bits(sel, d, w);
    end
    step(sel, 1'b1, 1'b0);
    ferr_end = ferr_of(sel);
  endtask

  task automatic rd_frame(input bit sel, input int aw, input int w, input logic [31:0] addr,
                          input int n, output logic [31:0] r0, r1, r2, output logic ferr_end);
    logic [31:0] got;
    r0 = '0; r1 = '0; r2 = '0;
    step(sel, 1'b0, 1'b0);
    send_bits(sel, 32'd1, 2);
    send_bits(sel, addr, aw);
    for (int k = 0; k < n; k++) begin
      got = '0;
      for (int j = 0; j < w; j++) begin
        step(sel, 1'b0, 1'b1);
        got = {got[30:0], miso_of(sel)};
      end
      if (k == 0) r0 = got;
      else if (k == 1) r1 = got;
      else r2 = got;
    end
    step(sel, 1'b1, 1'b0);
    ferr_end = ferr_of(sel);
  endtask

  task automatic test_reset_values;
    n_checks++;
    if ({miso_a, busy_a, ferr_a} !== 3'b000) $display("FAIL reset_a: got %b expected 000", {miso_a, busy_a, ferr_a});
    else n_pass++;
    n_checks++;
    if ({miso_b, busy_b, ferr_b} !== 3'b000) $display("FAIL reset_b: got %b expected 000", {miso_b, busy_b, ferr_b});
    else n_pass++;
  endtask

  task automatic test_single;
    logic [31:0] r0, r1, r2;
    logic fe;
    step(0, 1'b0, 1'b0);
    n_checks++;
    if (busy_a !== 1'b1) $display("FAIL busy_rise: got %b expected 1", busy_a);
    else n_pass++;
    send_bits(0, 32'd0, 2);
    send_bits(0, 32'h10, 8);
    send_bits(0, 32'hA5, 8);
    step(0, 1'b1, 1'b0);
    n_checks++;
    if ({busy_a, ferr_a} !== 2'b00) $display("FAIL write_end: got busy,ferr=%b expected 00", {busy_a, ferr_a});
    else n_pass++;
    rd_frame(0, 8, 8, 32'h10, 1, r0, r1, r2, fe);
    n_checks++;
    if (r0[7:0] !== 8'hA5) $display("FAIL single_read: got %h expected a5", r0[7:0]);
    else n_pass++;
    n_checks++;
    if (fe !== 1'b0) $display("FAIL read_end_ferr: got %b expected 0", fe);
    else n_pass++;
  endtask

  task automatic test_burst_wrap;
    logic [31:0] r0, r1, r2;
    logic fe;
    wr_frame(0, 8, 8, 32'hFE, 3, 32'h11, 32'h22, 32'h33, fe);
    n_checks++;
    if (fe !== 1'b0) $display("FAIL burst_wr_ferr: got %b expected 0", fe);
    else n_pass++;
    rd_frame(0, 8, 8, 32'hFE, 3, r0, r1, r2, fe);
    n_checks++;
    if ({r0[7:0], r1[7:0], r2[7:0]} !== 24'h112233)
      $display("FAIL burst_rd_fe: got %h expected 112233", {r0[7:0], r1[7:0], r2[7:0]});
    else n_pass++;
    rd_frame(0, 8, 8, 32'h00, 1, r0, r1, r2, fe);
    n_checks++;
    if (r0[7:0] !== 8'h33) $display("FAIL wrap_mem0: got %h expected 33", r0[7:0]);
    else n_pass++;
  endtask

  task automatic test_truncated;
    logic [31:0] r0, r1, r2;
    logic fe;
    wr_frame(0, 8, 8, 32'h20, 1, 32'h5A, 32'h0, 32'h0, fe);
    step(0, 1'b0, 1'b0);
    send_bits(0, 32'd0, 2);
    send_bits(0, 32'h20, 8);
    send_bits(0, 32'h1F, 5);
    step(0, 1'b1, 1'b0);
    n_checks++;
    if (ferr_a !== 1'b1) $display("FAIL trunc_wr_ferr: got %b expected 1", ferr_a);
    else n_pass++;
    step(0, 1'b1, 1'b0);
    n_checks++;
    if (ferr_a !== 1'b0) $display("FAIL trunc_wr_pulse_len: got %b expected 0", ferr_a);
    else n_pass++;
    rd_frame(0, 8, 8, 32'h20, 1, r0, r1, r2, fe);
    n_checks++;
    if (r0[7:0] !== 8'h5A) $display("FAIL trunc_wr_mem: got %h expected 5a", r0[7:0]);
    else n_pass++;
    step(0, 1'b0, 1'b0);
    send_bits(0, 32'd1, 2);
    send_bits(0, 32'h5, 3);
    step(0, 1'b1, 1'b0);
    n_checks++;
    if ({ferr_a, busy_a} !== 2'b10) $display("FAIL trunc_addr: got ferr,busy=%b expected 10", {ferr_a, busy_a});
    else n_pass++;
  endtask

  task automatic test_read_midword;
    step(0, 1'b0, 1'b0);
    send_bits(0, 32'd1, 2);
    send_bits(0, 32'h10, 8);
    for (int j = 0; j < 4; j++) step(0, 1'b0, 1'b0);
    step(0, 1'b1, 1'b0);
    n_checks++;
    if ({ferr_a, busy_a, miso_a} !== 3'b000)
      $display("FAIL read_midword_end: got ferr,busy,miso=%b expected 000", {ferr_a, busy_a, miso_a});
    else n_pass++;
  endtask

  task automatic test_invalid;
    logic [31:0] r0, r1, r2;
    logic fe;
    logic miso_seen;
    step(0, 1'b0, 1'b0);
    step(0, 1'b0, 1'b1);
    step(0, 1'b0, 1'b1);
    n_checks++;
    if (ferr_a !== 1'b1) $display("FAIL invalid_ferr: got %b expected 1", ferr_a);
    else n_pass++;
    miso_seen = 1'b0;
    for (int j = 0; j < 20; j++) begin
      step(0, 1'b0, 1'(j % 3 != 0));
      miso_seen = miso_seen | miso_a | ferr_a;
    end
    n_checks++;
    if (miso_seen !== 1'b0) $display("FAIL invalid_quiet: got %b expected 0", miso_seen);
    else n_pass++;
    step(0, 1'b1, 1'b0);
    n_checks++;
    if ({ferr_a, busy_a} !== 2'b00) $display("FAIL invalid_end: got ferr,busy=%b expected 00", {ferr_a, busy_a});
    else n_pass++;
    rd_frame(0, 8, 8, 32'hFE, 3, r0, r1, r2, fe);
    n_checks++;
    if ({r0[7:0], r1[7:0], r2[7:0]} !== 24'h112233)
      $display("FAIL invalid_mem: got %h expected 112233", {r0[7:0], r1[7:0], r2[7:0]});
    else n_pass++;
  endtask

  task automatic test_async_reset;
    logic [31:0] r0, r1, r2;
    logic fe;
    step(0, 1'b0, 1'b0);
    send_bits(0, 32'd1, 2);
    send_bits(0, 32'h10, 8);
    step(0, 1'b0, 1'b0);
    n_checks++;
    if ({busy_a, miso_a} !== 2'b11) $display("FAIL pre_reset_turn: got busy,miso=%b expected 11", {busy_a, miso_a});
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({miso_a, busy_a, ferr_a} !== 3'b000)
      $display("FAIL async_reset: got miso,busy,ferr=%b expected 000", {miso_a, busy_a, ferr_a});
    else n_pass++;
    ss_a = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 1'b1, 1'b0);
    n_checks++;
    if (busy_a !== 1'b0) $display("FAIL reset_idle: got busy %b expected 0", busy_a);
    else n_pass++;
    rd_frame(0, 8, 8, 32'h10, 1, r0, r1, r2, fe);
    n_checks++;
    if (r0[7:0] !== 8'hA5) $display("FAIL mem_survives_reset: got %h expected a5", r0[7:0]);
    else n_pass++;
  endtask

  task automatic test_param_sweep;
    logic [31:0] r0, r1, r2;
    logic fe;
    wr_frame(1, 4, 12, 32'hF, 2, 32'hABC, 32'h123, 32'h0, fe);
    n_checks++;
    if (fe !== 1'b0) $display("FAIL sweep_wr_ferr: got %b expected 0", fe);
    else n_pass++;
    rd_frame(1, 4, 12, 32'hF, 2, r0, r1, r2, fe);
    n_checks++;
    if ({r0[11:0], r1[11:0]} !== 24'hABC123)
      $display("FAIL sweep_burst_rd: got %h expected abc123", {r0[11:0], r1[11:0]});
    else n_pass++;
    rd_frame(1, 4, 12, 32'h0, 1, r0, r1, r2, fe);
    n_checks++;
    if (r0[11:0] !== 12'h123) $display("FAIL sweep_addr0: got %h expected 123", r0[11:0]);
    else n_pass++;
  endtask

  initial begin
    rst_n = 1'b0;
    ss_a = 1'b1; mosi_a = 1'b0;
    ss_b = 1'b1; mosi_b = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    test_reset_values();
    test_single();
    test_burst_wrap();
    test_truncated();
    test_read_midword();
    test_invalid();
    test_async_reset();
    test_param_sweep();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
